// File: rtl/m_axi_mem_prefetch_fifo_if.sv
// Handshake bundle between the prefetch FIFO and its user.
// The FIFO connects through the slave modport, the user through master.
interface m_axi_mem_prefetch_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   logic                  if_write;
   logic [DATA_WIDTH-1:0] if_din;
   logic                  if_full_n;
   logic                  if_almost_full;
   logic                  if_read;
   logic [DATA_WIDTH-1:0] if_dout;
   logic                  if_empty_n;
   logic [ADDR_WIDTH:0]   if_num_data_valid;
   logic                  if_ovf_err;
   logic                  if_udf_err;

   modport slave (
      input  if_write, if_din, if_read,
      output if_full_n, if_almost_full, if_dout, if_empty_n,
             if_num_data_valid, if_ovf_err, if_udf_err
   );

   modport master (
      output if_write, if_din, if_read,
      input  if_full_n, if_almost_full, if_dout, if_empty_n,
             if_num_data_valid, if_ovf_err, if_udf_err
   );
endinterface

// File: rtl/m_axi_mem_prefetch_fifo.sv
// FWFT FIFO: simple dual-port RAM (registered address and data) feeding a
// small credit-controlled prefetch buffer whose head register drives if_dout.
module m_axi_mem_prefetch_fifo #(
   parameter string MEM_STYLE  = "auto",
   parameter int    DATA_WIDTH = 32,
   parameter int    ADDR_WIDTH = 6,
   parameter int    DEPTH      = 64,
   parameter int    AF_MARGIN  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clk_en,
   m_axi_mem_prefetch_fifo_if.slave fif
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]         C_DEPTH  = CW'(DEPTH);
   localparam logic [CW-1:0]         C_ONE    = CW'(1);
   localparam logic [CW-1:0]         C_AF_THR = (AF_MARGIN >= DEPTH) ? CW'(0) : CW'(DEPTH - AF_MARGIN);
   localparam logic [ADDR_WIDTH-1:0] C_LAST   = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] C_A_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] C_A_ZERO = ADDR_WIDTH'(0);

   (* ram_style = MEM_STYLE *) logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH-1:0] r_raddr;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_v1;
   logic                  r_v2;
   logic [CW-1:0]         r_ram_cnt;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_q [0:3];
   logic [1:0]            r_pcnt;
   logic                  r_full_n;
   logic                  r_empty_n;
   logic                  r_af;
   logic                  r_ovf;
   logic                  r_udf;

   logic          w_wr;
   logic          w_rd;
   logic          w_arrive;
   logic          w_issue;
   logic [1:0]    w_inflight;
   logic [1:0]    w_ins;
   logic [1:0]    w_pcnt_nxt;
   logic [CW-1:0] w_count_nxt;
   logic [CW-1:0] w_ram_cnt_nxt;

   assign w_wr       = clk_en & fif.if_write & r_full_n;
   assign w_rd       = clk_en & fif.if_read & r_empty_n;
   assign w_arrive   = clk_en & r_v2;
   assign w_inflight = {1'b0, r_v1} + {1'b0, r_v2} + r_pcnt;
   // A RAM read is issued only when the prefetch buffer is sure to have room
   // when it lands, so the two-stage RAM pipeline never needs to stall.
   assign w_issue    = clk_en & (r_ram_cnt != {CW{1'b0}}) & ((w_inflight != 2'd3) | w_rd);
   assign w_ins      = r_pcnt - {1'b0, w_rd};
   assign w_pcnt_nxt = w_ins + {1'b0, w_arrive};

   // Next occupancy of the whole FIFO and of the RAM portion.
   always_comb begin
      w_count_nxt   = r_count;
      w_ram_cnt_nxt = r_ram_cnt;
      case ({w_wr, w_rd})
         2'b10:   w_count_nxt = r_count + C_ONE;
         2'b01:   w_count_nxt = r_count - C_ONE;
         default: w_count_nxt = r_count;
      endcase
      case ({w_wr, w_issue})
         2'b10:   w_ram_cnt_nxt = r_ram_cnt + C_ONE;
         2'b01:   w_ram_cnt_nxt = r_ram_cnt - C_ONE;
         default: w_ram_cnt_nxt = r_ram_cnt;
      endcase
   end

   // Storage array: write port and registered read data.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= fif.if_din;
      end
      if (clk_en) begin
         r_rdata <= r_mem[r_raddr];
      end
   end

   // Write/read pointers and RAM read pipeline valids.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wptr    <= C_A_ZERO;
         r_rptr    <= C_A_ZERO;
         r_raddr   <= C_A_ZERO;
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_ram_cnt <= {CW{1'b0}};
      end else if (clk_en) begin
         if (w_wr) begin
            r_wptr <= (r_wptr == C_LAST) ? C_A_ZERO : r_wptr + C_A_ONE;
         end
         if (w_issue) begin
            r_raddr <= r_rptr;
            r_rptr  <= (r_rptr == C_LAST) ? C_A_ZERO : r_rptr + C_A_ONE;
         end
         r_v1      <= w_issue;
         r_v2      <= r_v1;
         r_ram_cnt <= w_ram_cnt_nxt;
      end
   end

   // Prefetch buffer; slot 0 is the head word presented on if_dout.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            r_q[i] <= {DATA_WIDTH{1'b0}};
         end
         r_pcnt    <= 2'd0;
         r_empty_n <= 1'b0;
      end else if (clk_en) begin
         if (w_rd) begin
            r_q[0] <= r_q[1];
            r_q[1] <= r_q[2];
            r_q[2] <= r_q[3];
         end
         if (w_arrive) begin
            r_q[w_ins] <= r_rdata;
         end
         r_pcnt    <= w_pcnt_nxt;
         r_empty_n <= (w_pcnt_nxt != 2'd0);
      end
   end

   // Occupancy, level flags and sticky error flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count  <= {CW{1'b0}};
         r_full_n <= 1'b1;
         r_af     <= (C_AF_THR == {CW{1'b0}});
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (clk_en) begin
         r_count  <= w_count_nxt;
         r_full_n <= (w_count_nxt < C_DEPTH);
         r_af     <= (w_count_nxt >= C_AF_THR);
         if (fif.if_write & ~r_full_n) begin
            r_ovf <= 1'b1;
         end
         if (fif.if_read & ~r_empty_n) begin
            r_udf <= 1'b1;
         end
      end
   end

   assign fif.if_dout           = r_q[0];
   assign fif.if_empty_n        = r_empty_n;
   assign fif.if_full_n         = r_full_n;
   assign fif.if_almost_full    = r_af;
   assign fif.if_num_data_valid = r_count;
   assign fif.if_ovf_err        = r_ovf;
   assign fif.if_udf_err        = r_udf;
endmodule

// File: tb/tb_m_axi_mem_prefetch_fifo.sv
// Directed bench for m_axi_mem_prefetch_fifo; written words go into a
// scoreboard queue and a negedge monitor checks every accepted read.
module tb_m_axi_mem_prefetch_fifo;
   localparam int DW = 32;
   localparam int AW = 6;

   logic clk;
   logic reset;
   logic clk_en;
   int   checks;
   int   errors;
   logic [DW-1:0] exp_q [$];

   m_axi_mem_prefetch_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fif ();

   m_axi_mem_prefetch_fifo #(
      .MEM_STYLE("auto"), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(64), .AF_MARGIN(4)
   ) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .fif(fif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Read-side monitor: a read is accepted on the coming edge.
   always @(negedge clk) begin
      if (reset && clk_en && fif.if_read && fif.if_empty_n) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dout: read accepted with no word expected, got 0x%0h", fif.if_dout);
         end else begin
            chk("dout", {32'd0, fif.if_dout}, {32'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic en);
      clk_en = en;
      fif.if_write = 1'b0;
      fif.if_read = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      clk_en = 1'b1;
      exp_q.delete();
   endtask

   task automatic wr1(input logic [DW-1:0] d);
      fif.if_din = d;
      fif.if_write = 1'b1;
      exp_q.push_back(d);
      tick();
      fif.if_write = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_count"}, {57'd0, fif.if_num_data_valid}, 64'd0);
      chk({tag, "_empty_n"}, {63'd0, fif.if_empty_n}, 64'd0);
      chk({tag, "_full_n"}, {63'd0, fif.if_full_n}, 64'd1);
      chk({tag, "_dout"}, {32'd0, fif.if_dout}, 64'd0);
      chk({tag, "_af"}, {63'd0, fif.if_almost_full}, 64'd0);
      chk({tag, "_ovf"}, {63'd0, fif.if_ovf_err}, 64'd0);
      chk({tag, "_udf"}, {63'd0, fif.if_udf_err}, 64'd0);
   endtask

   task automatic fall_through(input string tag, input logic [DW-1:0] d);
      wr1(d);
      chk({tag, "_count1"}, {57'd0, fif.if_num_data_valid}, 64'd1);
      chk({tag, "_empty_k"}, {63'd0, fif.if_empty_n}, 64'd0);
      for (int j = 1; j <= 3; j++) begin
         tick();
         chk({tag, "_empty_lat"}, {63'd0, fif.if_empty_n}, (j == 3) ? 64'd1 : 64'd0);
      end
      chk({tag, "_dout_ft"}, {32'd0, fif.if_dout}, {32'd0, d});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      fif.if_din = '0;
      do_reset(1'b1);
      check_idle("rst");

      // Single word fall-through, then read it.
      fall_through("single", 32'hA5A5_A5A5);
      fif.if_read = 1'b1;
      tick();
      fif.if_read = 1'b0;
      chk("single_count0", {57'd0, fif.if_num_data_valid}, 64'd0);
      chk("single_empty0", {63'd0, fif.if_empty_n}, 64'd0);

      // Underflow, then write+read at occupancy 0.
      fif.if_read = 1'b1;
      tick();
      chk("udf_set", {63'd0, fif.if_udf_err}, 64'd1);
      chk("udf_count", {57'd0, fif.if_num_data_valid}, 64'd0);
      fif.if_din = 32'h0000_00C3;
      fif.if_write = 1'b1;
      exp_q.push_back(32'h0000_00C3);
      tick();
      fif.if_write = 1'b0;
      fif.if_read = 1'b0;
      chk("wr_rd_empty_count", {57'd0, fif.if_num_data_valid}, 64'd1);
      tick(); tick(); tick();
      chk("wr_rd_empty_vis", {63'd0, fif.if_empty_n}, 64'd1);
      fif.if_read = 1'b1;
      tick();
      fif.if_read = 1'b0;

      // Fill to full with 0..63.
      do_reset(1'b1);
      for (int i = 0; i < 64; i++) begin
         fif.if_din = DW'(i);
         fif.if_write = 1'b1;
         exp_q.push_back(DW'(i));
         tick();
         if (i == 58) chk("af_59", {63'd0, fif.if_almost_full}, 64'd0);
         if (i == 59) chk("af_60", {63'd0, fif.if_almost_full}, 64'd1);
         if (i == 62) chk("full_n_63", {63'd0, fif.if_full_n}, 64'd1);
         if (i == 63) chk("full_n_64", {63'd0, fif.if_full_n}, 64'd0);
      end
      fif.if_din = 32'd99;
      tick();
      fif.if_write = 1'b0;
      chk("ovf_set", {63'd0, fif.if_ovf_err}, 64'd1);
      chk("count_64", {57'd0, fif.if_num_data_valid}, 64'd64);
      tick(); tick(); tick();

      // Full: write and read on the same edge.
      fif.if_din = 32'd77;
      fif.if_write = 1'b1;
      fif.if_read = 1'b1;
      tick();
      fif.if_write = 1'b0;
      fif.if_read = 1'b0;
      chk("full_rw_count", {57'd0, fif.if_num_data_valid}, 64'd63);
      chk("full_rw_full_n", {63'd0, fif.if_full_n}, 64'd1);

      // 200-word stream with both sides held high; freeze mid-stream.
      fif.if_write = 1'b1;
      fif.if_read = 1'b1;
      for (int i = 0; i < 200; i++) begin
         fif.if_din = 32'd1000 + DW'(i);
         if (i == 100) begin
            clk_en = 1'b0;
            for (int j = 0; j < 5; j++) begin
               tick();
               chk("frz_count", {57'd0, fif.if_num_data_valid}, 64'd63);
               chk("frz_empty_n", {63'd0, fif.if_empty_n}, 64'd1);
               chk("frz_full_n", {63'd0, fif.if_full_n}, 64'd1);
               chk("frz_dout", {32'd0, fif.if_dout}, {32'd0, exp_q[0]});
            end
            clk_en = 1'b1;
         end
         exp_q.push_back(32'd1000 + DW'(i));
         tick();
         chk("stream_count", {57'd0, fif.if_num_data_valid}, 64'd63);
      end
      fif.if_write = 1'b0;
      fif.if_read = 1'b0;

      // Reset with 10 words stored (reset asserted while clk_en is low).
      do_reset(1'b1);
      for (int i = 0; i < 10; i++) wr1(32'h0BAD_0000 + DW'(i));
      tick(); tick(); tick(); tick();
      chk("ten_count", {57'd0, fif.if_num_data_valid}, 64'd10);
      do_reset(1'b0);
      check_idle("rst10");
      fall_through("post_rst", 32'h5A5A_0001);
      fif.if_read = 1'b1;
      tick();
      fif.if_read = 1'b0;
      tick();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      chk("end_empty_n", {63'd0, fif.if_empty_n}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/m_axi_mem_prefetch_fifo.md
M_AXI_MEM_PREFETCH_FIFO -- requirements
Module: m_axi_mem_prefetch_fifo

Interface
REQ-001 SHALL provide parameter MEM_STYLE, default "auto": RAM inference style attribute for the storage array.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 6: RAM address width; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL provide parameter DEPTH, default 64, legal range >= 4: total FIFO capacity in words, including prefetch stages.
REQ-005 SHALL provide parameter AF_MARGIN, default 4, range 0..DEPTH-1: almost-full threshold margin.
REQ-006 Ports, clock and reset first:
  clk  in  1  sole clock, all state on rising edge.
  reset  in  1  synchronous, active-low; 0 = reset.
  clk_en  in  1  global enable; 0 freezes all state.
  if_write  in  1  write request.
  if_din  in  DATA_WIDTH  write data.
  if_full_n  out  1  1 = write will be accepted.
  if_almost_full  out  1  occupancy >= DEPTH-AF_MARGIN.
  if_read  in  1  read request.
  if_dout  out  DATA_WIDTH  head word, valid when if_empty_n=1.
  if_empty_n  out  1  1 = head word present.
  if_num_data_valid  out  ADDR_WIDTH+1  occupancy count.
  if_ovf_err  out  1  sticky: write attempted while full.
  if_udf_err  out  1  sticky: read attempted while empty.

Function
REQ-007 Write accepted on an edge iff clk_en & if_write & if_full_n; read accepted iff clk_en & if_read & if_empty_n.
REQ-008 Storage SHALL be a simple dual-port RAM with registered read address and registered read data (2-edge RAM read latency), plus an output prefetch stage giving first-word-fall-through behaviour.
REQ-009 Occupancy = words accepted minus words read; if_num_data_valid equals occupancy exactly, updated on the accepting edge (write +1, read -1, both = unchanged).
REQ-010 if_full_n = (occupancy < DEPTH); if_almost_full = (occupancy >= DEPTH-AF_MARGIN); both registered, consistent with if_num_data_valid in the same cycle.
REQ-011 Simultaneous write and read at occupancy DEPTH: write rejected (if_full_n=0 decides), read accepted, occupancy becomes DEPTH-1.
REQ-012 Simultaneous write and read at occupancy 0: read rejected (if_empty_n=0), write accepted.
REQ-013 Fall-through latency: write accepted on edge k into a FIFO whose pipeline is empty -> if_empty_n=1 and if_dout=written word after edge k+3.
REQ-014 if_empty_n SHALL lag occupancy while words are in the RAM pipeline; it SHALL never be 1 with occupancy 0.
REQ-015 Throughput: with occupancy >= 3 and if_read held high, one word SHALL be delivered per enabled cycle, no bubbles; with if_write held high and not full, one word accepted per enabled cycle.
REQ-016 Ordering: words SHALL emerge in exact write order; no loss or duplication across RAM address wrap-around (DEPTH-1 -> 0), including non-power-of-two DEPTH.
REQ-017 if_dout SHALL hold stable while if_empty_n=1 and no read is accepted.
REQ-018 clk_en=0: no accepts, pointers, counters, RAM pipeline, outputs and error flags hold; resuming clk_en continues exactly where stopped.
REQ-019 if_ovf_err set on edge where clk_en & if_write & ~if_full_n; if_udf_err set on edge where clk_en & if_read & ~if_empty_n; both cleared only by reset.

Reset
REQ-020 reset=0 on an edge (independent of clk_en) SHALL clear pointers, occupancy and pipeline; then if_full_n=1, if_empty_n=0, if_dout=0, if_num_data_valid=0, if_almost_full=(AF_MARGIN>=DEPTH ? 1 : 0), both error flags 0.
REQ-021 Reset mid-operation discards all stored and in-flight words; RAM contents need not be cleared; first write after reset obeys REQ-013.

Verification
REQ-022 Bench SHALL cover, with defaults (DEPTH=64, AF_MARGIN=4):
  Single write 0xA5A5A5A5 at edge k into empty FIFO -> if_empty_n=1, if_dout=0xA5A5A5A5 after edge k+3; count=1 after edge k.
  64 back-to-back writes of 0..63 -> if_almost_full=1 after 60th write, if_full_n=0 after 64th; 65th write rejected, if_ovf_err=1, count stays 64.
  Full FIFO, write and read same edge -> read of 0 accepted, write rejected, count=63, if_full_n=1 next cycle.
  Continuous write+read for 200 words (crosses wrap three times) -> output sequence equals input, one word/cycle in steady state.
  clk_en=0 for 5 cycles mid-stream with if_read=1, if_write=1 -> all outputs and count unchanged; stream resumes without loss.
  reset=0 with 10 words stored -> count=0, if_empty_n=0, if_dout=0, errors 0; next word written appears 3 edges later.
